// File: rtl/unet_wrapper_pkg.sv
// -----------------------------------------------------------------------------
// unet_wrapper_pkg
// Shared definitions for the U-Net wrapper control blocks:
//   - fetch_state_e : state encoding of the descriptor fetcher FSM
//   - FLAG_WORD     : handshake value the PS writes into the flag word
//   - DESC_OFFSET   : byte distance from the flag word to descriptor 0
//   - MAX_NUM_WORDS : largest descriptor count a fetcher may be built with
//   - desc_addr()   : byte address of descriptor idx relative to the flag word
// -----------------------------------------------------------------------------
package unet_wrapper_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3,
    ACK   = 3'd4,
    DONE  = 3'd5
  } fetch_state_e;

  localparam logic [31:0] FLAG_WORD     = 32'h0005_0010;
  localparam logic [31:0] DESC_OFFSET   = 32'd4;
  localparam int unsigned MAX_NUM_WORDS = 16;

  // Descriptors are packed words directly after the flag word; 32-bit wrap is
  // accepted silently.
  function automatic logic [31:0] desc_addr(input logic [31:0] base,
                                            input logic [3:0]  idx);
    return base + DESC_OFFSET + {26'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Registered rising-edge detector for a level input.
//   clk   in  : rising-edge clock
//   rst_n in  : synchronous active-low reset
//   d     in  : level to watch
//   rise  out : one-cycle registered pulse, high the cycle after d is first
//               seen high following a low (or following reset)
// -----------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q_r;
  logic rise_r;

  // History cleared in reset, so a level already high at release reads as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q_r  <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      d_q_r  <= d;
      rise_r <= d & ~d_q_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/base_addr_fetch.sv
// -----------------------------------------------------------------------------
// base_addr_fetch
// After the poller raises transfer_done, reads NUM_WORDS layer base addresses
// from the BRAM words following the flag word and streams them out over a
// valid/ready interface, then raises fetch_done until transfer_done drops.
//
// Build option: define BASE_ACK_WRITEBACK_EN to overwrite the flag word with
// ACK_WORD once the last descriptor is accepted. Without it the write path is
// absent and ram_we / ram_wd_data are tied to zero.
//
// Parameters: START_ADDR (flag word byte address), NUM_WORDS (1..16),
//             RD_LATENCY (1..3 cycles), ACK_WORD (write-back value)
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   ram_clk, ram_rst       : BRAM clock (= clk) and reset (tied low)
//   ram_addr, ram_en       : BRAM byte address and enable
//   ram_we, ram_wd_data    : BRAM byte write enables and write data
//   ram_rd_data            : BRAM read data
//   transfer_done          : level from the handshake poller
//   desc_valid/ready/data  : descriptor stream
//   desc_index             : descriptor number of desc_data
//   fetch_done             : all descriptors accepted (level)
// -----------------------------------------------------------------------------
module base_addr_fetch
  import unet_wrapper_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h4580_0000,
  parameter int unsigned NUM_WORDS  = 8,
  parameter int unsigned RD_LATENCY = 2,
  parameter logic [31:0] ACK_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ram_clk,
  output logic        ram_rst,
  output logic [31:0] ram_addr,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_wd_data,
  input  logic [31:0] ram_rd_data,
  input  logic        transfer_done,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic [31:0] desc_data,
  output logic [3:0]  desc_index,
  output logic        fetch_done
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  fetch_state_e state_r, state_s;
  logic [3:0]   idx_r, idx_s;
  logic [1:0]   cnt_r, cnt_s;
  logic [31:0]  ram_addr_r, ram_addr_s;
  logic         ram_en_r, ram_en_s;
  logic         desc_valid_r, desc_valid_s;
  logic [31:0]  desc_data_r, desc_data_s;
  logic [3:0]   desc_index_r, desc_index_s;
  logic         fetch_done_r, fetch_done_s;
  logic         rise_s;
`ifdef BASE_ACK_WRITEBACK_EN
  logic [3:0]   ram_we_r, ram_we_s;
  logic [31:0]  ram_wd_r, ram_wd_s;
`else
  logic         unused_ack_s;
`endif

  rise_detect u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (transfer_done),
    .rise  (rise_s)
  );

  // Next-state and next-output logic; BRAM strobes are computed for the state
  // being entered so the registered outputs line up with that state.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    cnt_s        = cnt_r;
    ram_addr_s   = 32'd0;
    ram_en_s     = 1'b0;
    desc_valid_s = desc_valid_r;
    desc_data_s  = desc_data_r;
    desc_index_s = desc_index_r;
    fetch_done_s = fetch_done_r;
`ifdef BASE_ACK_WRITEBACK_EN
    ram_we_s     = 4'h0;
    ram_wd_s     = 32'd0;
`endif
    case (state_r)
      IDLE: begin
        fetch_done_s = 1'b0;
        if (rise_s) begin
          idx_s      = 4'd0;
          ram_en_s   = 1'b1;
          ram_addr_s = desc_addr(START_ADDR, 4'd0);
          state_s    = ISSUE;
        end else begin
          state_s    = IDLE;
        end
      end
      ISSUE: begin
        cnt_s   = 2'd0;
        state_s = WAIT;
      end
      WAIT: begin
        // The last WAIT cycle is the one where read data is valid.
        if (cnt_r == LAT_LAST) begin
          desc_valid_s = 1'b1;
          desc_data_s  = ram_rd_data;
          desc_index_s = idx_r;
          state_s      = OUT;
        end else begin
          cnt_s        = cnt_r + 2'd1;
        end
      end
      OUT: begin
        if (desc_ready) begin
          desc_valid_s = 1'b0;
          if (idx_r == LAST_IDX) begin
`ifdef BASE_ACK_WRITEBACK_EN
            ram_en_s     = 1'b1;
            ram_addr_s   = START_ADDR;
            ram_we_s     = 4'hF;
            ram_wd_s     = ACK_WORD;
            state_s      = ACK;
`else
            fetch_done_s = 1'b1;
            state_s      = DONE;
`endif
          end else begin
            idx_s      = idx_r + 4'd1;
            ram_en_s   = 1'b1;
            ram_addr_s = desc_addr(START_ADDR, idx_r + 4'd1);
            state_s    = ISSUE;
          end
        end else begin
          state_s = OUT;
        end
      end
      ACK: begin
        fetch_done_s = 1'b1;
        state_s      = DONE;
      end
      DONE: begin
        // Exit on the low level, not an edge, so a drop during the fetch re-arms at once.
        if (!transfer_done) begin
          fetch_done_s = 1'b0;
          state_s      = IDLE;
        end else begin
          fetch_done_s = 1'b1;
        end
      end
      default: begin
        desc_valid_s = 1'b0;
        fetch_done_s = 1'b0;
        state_s      = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= 4'd0;
      cnt_r        <= 2'd0;
      ram_addr_r   <= 32'd0;
      ram_en_r     <= 1'b0;
      desc_valid_r <= 1'b0;
      desc_data_r  <= 32'd0;
      desc_index_r <= 4'd0;
      fetch_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      cnt_r        <= cnt_s;
      ram_addr_r   <= ram_addr_s;
      ram_en_r     <= ram_en_s;
      desc_valid_r <= desc_valid_s;
      desc_data_r  <= desc_data_s;
      desc_index_r <= desc_index_s;
      fetch_done_r <= fetch_done_s;
    end
  end

`ifdef BASE_ACK_WRITEBACK_EN
  // Flag-word write-back strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_we_r <= 4'h0;
      ram_wd_r <= 32'd0;
    end else begin
      ram_we_r <= ram_we_s;
      ram_wd_r <= ram_wd_s;
    end
  end

  assign ram_we      = ram_we_r;
  assign ram_wd_data = ram_wd_r;
`else
  assign unused_ack_s = ^ACK_WORD;
  assign ram_we       = 4'h0;
  assign ram_wd_data  = 32'd0;
`endif

  assign ram_clk    = clk;
  assign ram_rst    = 1'b0;
  assign ram_addr   = ram_addr_r;
  assign ram_en     = ram_en_r;
  assign desc_valid = desc_valid_r;
  assign desc_data  = desc_data_r;
  assign desc_index = desc_index_r;
  assign fetch_done = fetch_done_r;

endmodule

// File: tb/tb_base_addr_fetch.sv
// -----------------------------------------------------------------------------
// tb_base_addr_fetch
// Three fetchers (read latency 1, 2, 3) share transfer_done and reset; each has
// its own BRAM model, ready driver and transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_base_addr_fetch;
  import unet_wrapper_pkg::*;

  localparam logic [31:0] START = 32'h4580_0000;
  localparam int          NW    = 8;
  localparam logic [31:0] ACKW  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        transfer_done;
  logic        flag_load;
  logic [31:0] ref_words [0:15];
  int          ready_mode = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int LAT = g + 1;

    logic        ram_clk, ram_rst, ram_en, desc_valid, desc_ready, fetch_done;
    logic [31:0] ram_addr, ram_wd_data, ram_rd_data, desc_data;
    logic [3:0]  ram_we, desc_index;
    logic [31:0] flag_q;
    logic [31:0] pipe [0:2];

    base_addr_fetch #(
      .START_ADDR (START),
      .NUM_WORDS  (NW),
      .RD_LATENCY (LAT),
      .ACK_WORD   (ACKW)
    ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ram_clk       (ram_clk),
      .ram_rst       (ram_rst),
      .ram_addr      (ram_addr),
      .ram_en        (ram_en),
      .ram_we        (ram_we),
      .ram_wd_data   (ram_wd_data),
      .ram_rd_data   (ram_rd_data),
      .transfer_done (transfer_done),
      .desc_valid    (desc_valid),
      .desc_ready    (desc_ready),
      .desc_data     (desc_data),
      .desc_index    (desc_index),
      .fetch_done    (fetch_done)
    );

    function automatic logic [31:0] bram_word(input logic [31:0] a);
      logic [31:0] w;
      w = (a - START) >> 2;
      if (w == 32'd0)       return flag_q;
      else if (w <= 32'd16) return ref_words[w[3:0] - 4'd1];
      else                  return 32'hDEAD_BEEF;
    endfunction

    // BRAM: LAT-stage read pipeline; garbage when not enabled exposes bad capture timing.
    always @(posedge clk) begin
      if (flag_load) flag_q <= FLAG_WORD;
      else if (ram_en && ram_we == 4'hF && ram_addr == START) flag_q <= ram_wd_data;
      pipe[0] <= ram_en ? bram_word(ram_addr) : 32'hBAD0_0000;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign ram_rd_data = pipe[LAT-1];

    // Consumer: always ready, random ready, or a 5-cycle stall on index 3.
    int stall = 0;
    initial begin
      desc_ready = 1'b0;
      forever begin
        @(posedge clk); #1;
        case (ready_mode)
          0: desc_ready = 1'b1;
          1: desc_ready = ($urandom_range(0, 9) < 7);
          default: begin
            if (desc_valid && desc_index == 4'd3) begin
              if (stall < 5) begin desc_ready = 1'b0; stall++; end
              else desc_ready = 1'b1;
            end else begin
              stall = 0;
              desc_ready = 1'b1;
            end
          end
        endcase
      end
    end

    // Reference model: tracks the fetch as a sequence of timed events.
    int  exp_idx = 0, en_cyc = -1, vrise_cyc = -1, ack_cyc = -1, done_cyc = -1, done_cnt = 0;
    bit  active = 1'b0, exp_valid = 1'b0, exp_done = 1'b0, td_prev = 1'b0, rst_prev = 1'b1;
    logic [31:0] hs_log [$];
    logic [31:0] en_log [$];
    initial begin
      forever begin
        @(negedge clk);
        if (!rst_prev) begin
          chk("rst_ram_addr", ram_addr, 32'd0);
          chk("rst_ram_en", 32'(ram_en), 32'd0);
          chk("rst_ram_we", 32'(ram_we), 32'd0);
          chk("rst_ram_wd", ram_wd_data, 32'd0);
          chk("rst_desc_valid", 32'(desc_valid), 32'd0);
          chk("rst_desc_data", desc_data, 32'd0);
          chk("rst_desc_index", 32'(desc_index), 32'd0);
          chk("rst_fetch_done", 32'(fetch_done), 32'd0);
          chk("ram_rst", 32'(ram_rst), 32'd0);
          chk("ram_clk", 32'(ram_clk), 32'(clk));
          exp_idx = 0; en_cyc = -1; vrise_cyc = -1; ack_cyc = -1; done_cyc = -1;
          active = 1'b0; exp_valid = 1'b0; exp_done = 1'b0; td_prev = 1'b0;
        end
        if (rst_n) begin
          if (cyc == vrise_cyc) exp_valid = 1'b1;
          if (cyc == done_cyc) begin exp_done = 1'b1; done_cnt++; end
          chk("desc_valid", 32'(desc_valid), 32'(exp_valid));
          if (exp_valid) begin
            chk("desc_data", desc_data, ref_words[exp_idx]);
            chk("desc_index", 32'(desc_index), 32'(exp_idx));
          end
          chk("ram_en", 32'(ram_en), 32'(cyc == en_cyc || cyc == ack_cyc));
          if (cyc == en_cyc) begin
            chk("rd_addr", ram_addr, START + 32'd4 + 32'(4 * exp_idx));
            chk("rd_we", 32'(ram_we), 32'd0);
            en_log.push_back(ram_addr);
            vrise_cyc = cyc + LAT + 1;
          end else if (cyc == ack_cyc) begin
            chk("ack_addr", ram_addr, START);
            chk("ack_we", 32'(ram_we), 32'hF);
            chk("ack_wd", ram_wd_data, ACKW);
          end else begin
            chk("ram_we", 32'(ram_we), 32'd0);
            chk("ram_wd", ram_wd_data, 32'd0);
          end
          chk("fetch_done", 32'(fetch_done), 32'(exp_done));
          if (exp_valid && desc_ready) begin
            hs_log.push_back(desc_data);
            exp_valid = 1'b0;
            if (exp_idx == NW - 1) begin
`ifdef BASE_ACK_WRITEBACK_EN
              ack_cyc  = cyc + 1;
              done_cyc = cyc + 2;
`else
              done_cyc = cyc + 1;
`endif
            end else begin
              exp_idx++;
              en_cyc = cyc + 1;
            end
          end
          if (exp_done && !transfer_done) begin
            exp_done = 1'b0;
            active   = 1'b0;
          end
          if (!active && transfer_done && !td_prev) begin
            active  = 1'b1;
            exp_idx = 0;
            en_cyc  = cyc + 2;
          end
        end
        td_prev  = rst_n ? transfer_done : 1'b0;
        rst_prev = rst_n;
      end
    end
  end

  function automatic bit all_idle();
    return !g_lat[0].active && !g_lat[1].active && !g_lat[2].active;
  endfunction

  function automatic bit all_done(input int target);
    return g_lat[0].done_cnt >= target && g_lat[1].done_cnt >= target && g_lat[2].done_cnt >= target;
  endfunction

  task automatic wait_fetches(input int target);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (all_done(target)) break;
      @(posedge clk); #1;
    end
    chk("fetch_timeout", 32'(all_done(target)), 32'd1);
  endtask

  // Drop transfer_done, wait for every block to leave DONE, hold low, raise again.
  task automatic rearm(input int low_cycles, input bit new_content);
    int k;
    transfer_done = 1'b0;
    for (k = 0; k < 500; k++) begin
      if (all_idle()) break;
      @(posedge clk); #1;
    end
    chk("idle_timeout", 32'(all_idle()), 32'd1);
    if (new_content) begin
      for (int i = 0; i < 16; i++) ref_words[i] = $urandom();
    end
    flag_load = 1'b1;
    repeat (low_cycles) begin @(posedge clk); #1; end
    flag_load = 1'b0;
    transfer_done = 1'b1;
  endtask

  initial begin
    int target;
    int sz0;
    int k;
    rst_n = 1'b0;
    transfer_done = 1'b0;
    flag_load = 1'b1;
    for (int i = 0; i < 16; i++) ref_words[i] = 32'h1000_0000 + 32'(i);
    repeat (3) begin @(posedge clk); #1; end
    flag_load = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Basic fetch, always ready.
    transfer_done = 1'b1;
    target = 1;
    wait_fetches(target);
    repeat (2) begin @(posedge clk); #1; end
    chk("basic_count", 32'(g_lat[1].hs_log.size()), 32'd8);
    chk("basic_first", g_lat[1].hs_log[0], 32'h1000_0000);
    chk("basic_last", g_lat[1].hs_log[7], 32'h1000_0007);
    chk("basic_addr0", g_lat[1].en_log[0], 32'h4580_0004);
    chk("basic_addr7", g_lat[1].en_log[7], 32'h4580_0020);
`ifdef BASE_ACK_WRITEBACK_EN
    chk("flag_wb0", g_lat[0].flag_q, ACKW);
    chk("flag_wb1", g_lat[1].flag_q, ACKW);
    chk("flag_wb2", g_lat[2].flag_q, ACKW);
`else
    chk("flag_kept0", g_lat[0].flag_q, FLAG_WORD);
    chk("flag_kept1", g_lat[1].flag_q, FLAG_WORD);
    chk("flag_kept2", g_lat[2].flag_q, FLAG_WORD);
`endif

    // Re-arm with backpressure on index 3.
    ready_mode = 2;
    rearm(3, 1'b0);
    target++;
    wait_fetches(target);

    // Randomised rounds; sometimes transfer_done drops during the fetch.
    ready_mode = 1;
    for (int r = 0; r < 5; r++) begin
      rearm($urandom_range(1, 4), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(3, 25)) begin @(posedge clk); #1; end
        transfer_done = 1'b0;
      end
      target++;
      wait_fetches(target);
    end

    // Reset during WAIT of index 2 (latency-2 block); transfer_done stays high.
    ready_mode = 0;
    rearm(3, 1'b1);
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (g_lat[1].ram_en && g_lat[1].ram_addr == START + 32'd12) break;
    end
    chk("idx2_issue_seen", 32'(k < 200), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    sz0 = g_lat[1].hs_log.size();
    rst_n = 1'b1;
    target++;
    wait_fetches(target);
    chk("restart_count", 32'(g_lat[1].hs_log.size() - sz0), 32'd8);

    transfer_done = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
